bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
Two-master, three-slave arbiter for the system bus. It accepts approval requests from master 1 and master 2 and checks that the addressed slave is ready. It grants bus ownership to exactly one master at a time and drives the master/slave routing selects used by the bus multiplexers. Ownership is held for the whole transaction, which may be a burst, and a watchdog reclaims the bus from a master that never releases it.

Parameters:
TIMEOUT, 4095, maximum cycles a master may hold a grant before forced release
CNT_W, 12, width of ownership counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
approval_request_m1  input  1  master 1 requests bus; held high for the whole transaction
slave_select_m1  input  2  master 1 target: 00=s1, 01=s2, 10=s3, 11=invalid
approval_request_m2  input  1  master 2 requests bus
slave_select_m2  input  2  master 2 target, same encoding
slave_ready_s1  input  1  slave 1 idle, able to accept a transaction
slave_ready_s2  input  1  slave 2 idle
slave_ready_s3  input  1  slave 3 idle
approval_grant_m1  output  1  master 1 owns bus
approval_grant_m2  output  1  master 2 owns bus
master_sel  output  1  routing select: 0=m1, 1=m2; valid while bus_busy
slave_sel  output  2  latched target slave of current owner; valid while bus_busy
bus_busy  output  1  high while any grant is active
timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Clock, reset and register rules:
  - One clock (clk), reset asynchronous and active-low.
  - All outputs are registered.
- While reset is low:
  - Both grants, bus_busy and timeout are 0.
  - master_sel=0, slave_sel=00, state=IDLE, counter=0.
  - The round-robin pointer resets to "m2 last served", so m1 wins the first tie.
- Eligibility:
  - A master is eligible when its request is high, its select is not 11, and the selected slave_ready is 1.
  - A request with select 11 is never granted and does not block the other master.
- States: IDLE, OWN_M1, OWN_M2, TURN.
- IDLE:
  - Only m1 eligible: go to OWN_M1. Only m2 eligible: go to OWN_M2.
  - Both eligible: the master not served last wins (round robin).
  - On the transition edge: grant goes high, master_sel is set, slave_sel latches the winner's select, bus_busy=1, counter cleared.
  - Latency from eligible request (sampled at edge N) to grant high is 1 cycle (visible after edge N).
  - Neither eligible: stay in IDLE.
- OWN_Mx:
  - Grant held; slave_sel frozen. Changes to the owner's slave_select or to slave_ready are ignored.
  - Counter increments each cycle.
  - Owner request low: go to TURN. Grant drops on that edge; the pointer records x as last served.
  - Counter == TIMEOUT with request still high: go to TURN. Grant drops, timeout pulses high for exactly that one cycle, pointer updated.
  - Request drop and timeout on the same cycle: treated as a normal release, no timeout pulse.
- TURN:
  - One idle turnaround cycle. No grant, bus_busy=0, master_sel/slave_sel hold their last values.
  - Unconditionally go to IDLE.
  - The earliest regrant is therefore 2 cycles after release; no back-to-back grants.
- After a timeout, the timed-out master keeps its request high. It is treated as a new request and competes normally in round robin, so the other master wins any tie.
- The non-owner's request is ignored until IDLE. Requests are not queued; a master must hold its request until granted.
- Invariants:
  - approval_grant_m1 & approval_grant_m2 is never 1.
  - bus_busy == (approval_grant_m1 | approval_grant_m2).
- Reset asserted mid-ownership: all grants drop immediately (asynchronous), and the transaction is abandoned.

Test Plan:
- Single request: after reset release, m1 req=1, sel=01, s2 ready=1 -> approval_grant_m1=1 one cycle later, master_sel=0, slave_sel=01, bus_busy=1. Drop req -> grant 0 next edge; TURN for 1 cycle, then IDLE.
- Tie and fairness: both request, targets s1/s3 both ready -> m1 granted first. m1 releases while m2 holds req -> m2 granted exactly 2 cycles after m1's grant drops. Repeat the tie -> m1 wins again (alternation).
- Slave busy: m1 targets s1 with ready=0, m2 targets s2 with ready=1 -> m2 granted, m1 not. Then set s1 ready=1 -> m1 still waits until m2 releases.
- Invalid select: m1 sel=11 req=1 alone for 20 cycles -> no grant, bus_busy stays 0.
- Timeout: TIMEOUT=8, m2 holds req indefinitely -> grant high for 9 cycles (counter 0..8). timeout pulses 1 cycle, grant drops, and m2 is regranted after TURN+IDLE if it is the only requester.
- Async reset mid-burst: while m1 is granted, pulse reset low between clock edges -> grant/bus_busy go 0 without waiting for a clock edge. After release, the first tie goes to m1.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - Two-master, three-slave round-robin bus arbiter with ownership watchdog.
module bus_arbiter #(
    parameter int TIMEOUT = 4095,
    parameter int CNT_W   = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       approval_request_m1,
    input  logic [1:0] slave_select_m1,
    input  logic       approval_request_m2,
    input  logic [1:0] slave_select_m2,
    input  logic       slave_ready_s1,
    input  logic       slave_ready_s2,
    input  logic       slave_ready_s3,
    output logic       approval_grant_m1,
    output logic       approval_grant_m2,
    output logic       master_sel,
    output logic [1:0] slave_sel,
    output logic       bus_busy,
    output logic       timeout
);

    typedef enum logic [1:0] {IDLE, OWN_M1, OWN_M2, TURN} state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_m2, last_m2_nxt;
    logic             master_sel_nxt;
    logic [1:0]       slave_sel_nxt;
    logic             timeout_nxt;
    logic             grant_m1_nxt, grant_m2_nxt;
    logic [3:0]       ready_vec;
    logic             elig_m1, elig_m2;

    // Index 3 is the invalid select; tying it low makes such a request never eligible.
    assign ready_vec = {1'b0, slave_ready_s3, slave_ready_s2, slave_ready_s1};
    assign elig_m1   = approval_request_m1 && ready_vec[slave_select_m1];
    assign elig_m2   = approval_request_m2 && ready_vec[slave_select_m2];

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_m2_nxt    = last_m2;
        master_sel_nxt = master_sel;
        slave_sel_nxt  = slave_sel;
        timeout_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (elig_m1 && (!elig_m2 || last_m2)) begin
                    state_nxt      = OWN_M1;
                    master_sel_nxt = 1'b0;
                    slave_sel_nxt  = slave_select_m1;
                    cnt_nxt        = '0;
                end else if (elig_m2) begin
                    state_nxt      = OWN_M2;
                    master_sel_nxt = 1'b1;
                    slave_sel_nxt  = slave_select_m2;
                    cnt_nxt        = '0;
                end
            end
            OWN_M1: begin
                if (!approval_request_m1) begin
                    state_nxt   = TURN;
                    last_m2_nxt = 1'b0;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_nxt   = TURN;
                    last_m2_nxt = 1'b0;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            OWN_M2: begin
                if (!approval_request_m2) begin
                    state_nxt   = TURN;
                    last_m2_nxt = 1'b1;
                end else if (cnt == TIMEOUT_CNT) begin
                    state_nxt   = TURN;
                    last_m2_nxt = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        grant_m1_nxt = (state_nxt == OWN_M1);
        grant_m2_nxt = (state_nxt == OWN_M2);
    end

    // Pointer resets to "m2 served last" so m1 takes the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            cnt               <= '0;
            last_m2           <= 1'b1;
            approval_grant_m1 <= 1'b0;
            approval_grant_m2 <= 1'b0;
            master_sel        <= 1'b0;
            slave_sel         <= 2'b00;
            bus_busy          <= 1'b0;
            timeout           <= 1'b0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            last_m2           <= last_m2_nxt;
            approval_grant_m1 <= grant_m1_nxt;
            approval_grant_m2 <= grant_m2_nxt;
            master_sel        <= master_sel_nxt;
            slave_sel         <= slave_sel_nxt;
            bus_busy          <= grant_m1_nxt | grant_m2_nxt;
            timeout           <= timeout_nxt;
        end
    end

endmodule
